instruction_loader_memory: RTL
==============================

INSTRUCTION_LOADER_MEMORY -- requirements
Module: instruction_loader_memory

Interface
REQ-001 Parameter NB, 32: instruction word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter TAM, 256: depth in words; SHALL be a power of two, at least 4.
REQ-003 Parameter NB_BYTE, 8: loader byte width.
REQ-004 Parameter NB_ADDR, $clog2(TAM): internal word-address width.
REQ-005 Ports SHALL be, clock and reset first:
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_pc  in  NB  byte address for instruction fetch.
- i_load_start  in  1  one-cycle pulse that opens a new load session.
- i_load_valid  in  1  i_load_byte is valid this cycle.
- i_load_byte  in  NB_BYTE  next program byte, little-endian.
- o_instruction  out  NB  fetched word.
- o_pc_out_of_range  out  1  i_pc word index >= TAM.
- o_load_busy  out  1  FSM in LOAD.
- o_load_done  out  1  session ended; sticky until the next start.
- o_load_error  out  1  session ended without HALT.
- o_word_count  out  NB_ADDR+1  words written this session.

Function
REQ-006 Fetch SHALL be combinational: o_instruction = memory[i_pc[NB-1:2]] when in range, else NOP_INSTR. o_pc_out_of_range SHALL follow the same index test.
REQ-007 Fetch SHALL ignore i_pc[1:0].
REQ-008 FSM states SHALL be IDLE, LOAD and DONE.
REQ-009 Transitions:
- IDLE to LOAD on i_load_start.
- LOAD to DONE on HALT written or on memory full.
- DONE to LOAD on i_load_start.
REQ-010 i_load_start in any state, including LOAD, SHALL clear the byte counter, write address, o_word_count, o_load_done and o_load_error, and enter LOAD the next cycle.
REQ-011 In LOAD, each i_load_valid byte SHALL fill lane byte_cnt of the assembly register; byte 0 is bits [7:0]. byte_cnt SHALL wrap modulo NB/NB_BYTE.
REQ-012 On the last byte, the full word SHALL be written to memory[wr_addr] at that same edge, using the incoming byte directly. wr_addr and o_word_count SHALL then increment.
REQ-013 If the written word equals HALT_INSTR, the FSM SHALL go to DONE with o_load_done=1 and o_load_error=0. The HALT word itself SHALL be stored and counted.
REQ-014 If a non-HALT word is written to index TAM-1, the FSM SHALL go to DONE with o_load_done=1 and o_load_error=1, and o_word_count=TAM.
REQ-015 Bytes arriving in IDLE or DONE SHALL be ignored, with no write and no counter change.
REQ-016 Words not written in a session SHALL keep their previous contents.
REQ-017 Fetch during LOAD is legal. A word written at edge N SHALL be visible at o_instruction after edge N.
REQ-018 i_load_start and i_load_valid in the same cycle: start wins and the byte is discarded.

Reset
REQ-019 While i_reset=0, the FSM SHALL be IDLE and the following SHALL be 0: byte_cnt, wr_addr, assembly register, o_load_busy, o_load_done, o_load_error, o_word_count.
REQ-020 Memory contents SHALL NOT be reset; they SHALL be zero at elaboration. Reset during LOAD leaves already-written words intact.
REQ-021 Reset assertion SHALL be asynchronous; deassertion is synchronous to i_clk from upstream.

Structure
REQ-022 HALT_INSTR (32'hFFFFFFFF), NOP_INSTR (32'h00000000) and the FSM state encoding SHALL live in the shared instruction_constants package/header.
REQ-023 One sub-module, byte_word_assembler, SHALL hold byte_cnt and the assembly register. It SHALL output a word-valid pulse and the word, and is cleared by start or reset. The memory array and FSM SHALL stay in the top.

Verification
REQ-024 Load bytes 13,00,00,00 and then FF,FF,FF,FF. Required: memory[0]=0x00000013, memory[1]=HALT, o_word_count=2, done=1, error=0.
REQ-025 Load 256 words with no HALT. Required: error=1 and done=1 on the edge after the 1024th byte, o_word_count=256; a 1025th byte causes no write.
REQ-026 Send 2 bytes, then i_load_start, then 4 bytes AA,BB,CC,DD. Required: memory[0]=0xDDCCBBAA and the partial word discarded.
REQ-027 Assert i_reset=0 mid-word after 5 complete words, then release. Required: IDLE, outputs 0, words 0-4 intact, and a following byte is ignored.
REQ-028 Drive i_pc=0x400 with TAM=256. Required: o_pc_out_of_range=1 and o_instruction=0. Drive i_pc=0x006. Required: memory[1] returned.
REQ-029 Fetch i_pc=0x004 while word 1 is being written. Required: the old value before the write edge and the new value after it.

Source files
------------

// File: rtl/instruction_constants_pkg.sv
// Shared instruction encodings and loader FSM state encoding.
// Pure declarations: no latency, no backpressure.
package instruction_constants;

   localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } load_state_t;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs little-endian bytes into words; word_vld fires combinationally with the last byte.
// No backpressure: every byte_vld byte is consumed, clear discards any partial word.
module byte_word_assembler #(
   parameter int NB      = 32,
   parameter int NB_BYTE = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               byte_vld,
   input  logic [NB_BYTE-1:0] byte_dat,
   output logic               word_vld,
   output logic [NB-1:0]      word_dat
);

   localparam int LANES = NB / NB_BYTE;
   localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

   logic [CNT_W-1:0]                 byte_cnt;
   // Only the lower lanes are stored; the top lane comes straight from byte_dat.
   logic [(LANES-1)*NB_BYTE-1:0]     low_lanes;
   logic                             last_lane;

   assign last_lane = (byte_cnt == CNT_W'(LANES - 1));
   assign word_vld  = byte_vld && last_lane;
   assign word_dat  = {byte_dat, low_lanes};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt  <= '0;
         low_lanes <= '0;
      end else if (clear) begin
         byte_cnt  <= '0;
         low_lanes <= '0;
      end else if (byte_vld) begin
         if (last_lane) begin
            byte_cnt <= '0;
         end else begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            low_lanes[byte_cnt*NB_BYTE +: NB_BYTE] <= byte_dat;
         end
      end
   end

endmodule

// File: rtl/instruction_loader_memory.sv
// Byte-stream program loader into a word memory with combinational fetch (0-cycle read, write visible next edge).
// No backpressure: bytes outside LOAD are dropped; a start pulse aborts and restarts any session.
module instruction_loader_memory
   import instruction_constants::*;
#(
   parameter int NB      = 32,
   parameter int TAM     = 256,
   parameter int NB_BYTE = 8,
   parameter int NB_ADDR = $clog2(TAM)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NB-1:0]      i_pc,
   input  logic               i_load_start,
   input  logic               i_load_valid,
   input  logic [NB_BYTE-1:0] i_load_byte,
   output logic [NB-1:0]      o_instruction,
   output logic               o_pc_out_of_range,
   output logic               o_load_busy,
   output logic               o_load_done,
   output logic               o_load_error,
   output logic [NB_ADDR:0]   o_word_count
);

   // Memory is deliberately not reset; it starts at zero and survives resets.
   logic [NB-1:0] mem [TAM] = '{default: '0};

   load_state_t        state, state_nxt;
   logic [NB_ADDR-1:0] wr_addr;
   logic               byte_take;
   logic               word_vld;
   logic [NB-1:0]      word_dat;
   logic               is_halt;
   logic               at_last;
   logic [NB-3:0]      fetch_idx;
   logic               pc_unused;

   // Start wins over a same-cycle byte.
   assign byte_take = (state == ST_LOAD) && i_load_valid && !i_load_start;

   byte_word_assembler #(
      .NB      (NB),
      .NB_BYTE (NB_BYTE)
   ) u_asm (
      .clk      (i_clk),
      .rst_n    (i_reset),
      .clear    (i_load_start),
      .byte_vld (byte_take),
      .byte_dat (i_load_byte),
      .word_vld (word_vld),
      .word_dat (word_dat)
   );

   assign is_halt = (word_dat == NB'(HALT_INSTR));
   assign at_last = (wr_addr == NB_ADDR'(TAM - 1));

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (i_load_start)
         state_nxt = ST_LOAD;
      else if ((state == ST_LOAD) && word_vld && (is_halt || at_last))
         state_nxt = ST_DONE;
   end

   always_comb begin
      o_load_busy = (state == ST_LOAD);
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         wr_addr      <= '0;
         o_word_count <= '0;
         o_load_done  <= 1'b0;
         o_load_error <= 1'b0;
      end else if (i_load_start) begin
         wr_addr      <= '0;
         o_word_count <= '0;
         o_load_done  <= 1'b0;
         o_load_error <= 1'b0;
      end else if (word_vld) begin
         wr_addr      <= wr_addr + NB_ADDR'(1);
         o_word_count <= o_word_count + (NB_ADDR + 1)'(1);
         if (is_halt) begin
            o_load_done  <= 1'b1;
            o_load_error <= 1'b0;
         end else if (at_last) begin
            o_load_done  <= 1'b1;
            o_load_error <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (word_vld) mem[wr_addr] <= word_dat;
   end

   // Byte offset within the word is irrelevant to fetch.
   assign fetch_idx         = i_pc[NB-1:2];
   assign pc_unused         = ^i_pc[1:0];
   assign o_pc_out_of_range = (fetch_idx >= (NB-2)'(TAM));
   assign o_instruction     = o_pc_out_of_range ? NB'(NOP_INSTR) : mem[fetch_idx[NB_ADDR-1:0]];

endmodule
